// File: rtl/imu_sample_fifo.sv
// Frame FIFO between the MPU-6050 reader and a slower consumer.
// It captures a 96-bit frame on each rising edge of in_valid and replays it as six 16-bit words.
module imu_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [15:0]   in_accx,
  input  logic [15:0]   in_accy,
  input  logic [15:0]   in_accz,
  input  logic [15:0]   in_gyrox,
  input  logic [15:0]   in_gyroy,
  input  logic [15:0]   in_gyroz,
  input  logic          flush,
  output logic [15:0]   out_data,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [7:0]    ovf_cnt
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [2:0]    LAST_WORD  = 3'd5;

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [2:0]    widx;
  logic          in_prev;

  logic          cap;
  logic          accept;
  logic          pop;
  logic          push;
  logic          drop;
  logic [95:0]   head;

  assign cap    = in_valid & ~in_prev;
  assign accept = out_valid & out_ready;
  assign pop    = accept & (widx == LAST_WORD);
  // A last-word pop frees a slot in the same cycle, so a full FIFO can still take a frame.
  assign push   = cap & ((count != FULL_COUNT) | pop);
  assign drop   = cap & ~flush & ~push;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign out_valid = ~empty;
  assign out_idx   = widx;
  assign out_last  = (widx == LAST_WORD);
  assign head      = mem[rp];

  always_comb begin
    out_data = 16'h0000;
    if (!empty) begin
      case (widx)
        3'd0:    out_data = head[15:0];
        3'd1:    out_data = head[31:16];
        3'd2:    out_data = head[47:32];
        3'd3:    out_data = head[63:48];
        3'd4:    out_data = head[79:64];
        default: out_data = head[95:80];
      endcase
    end
  end

  // The storage array is not reset; out_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem[wp] <= {in_gyroz, in_gyroy, in_gyrox, in_accz, in_accy, in_accx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_prev <= 1'b0;
      ovf_cnt <= 8'd0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      widx    <= 3'd0;
    end else begin
      in_prev <= in_valid;
      if (drop && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
      // Flush overrides both push and pop and discards any capture in the same cycle.
      if (flush) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
        widx  <= 3'd0;
      end else begin
        if (push) begin
          wp <= wp + PTR_ONE;
        end
        if (accept) begin
          if (widx == LAST_WORD) begin
            widx <= 3'd0;
            rp   <= rp + PTR_ONE;
          end else begin
            widx <= widx + 3'd1;
          end
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imu_sample_fifo.sv
// Randomised and directed bench for imu_sample_fifo: a queue-of-frames reference model feeds
// a word scoreboard that is checked by an independent negedge monitor.
module tb_imu_sample_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [95:0] in_frame;
  logic        flush;
  logic        out_ready;
  logic [15:0] in_accx, in_accy, in_accz, in_gyrox, in_gyroy, in_gyroz;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [7:0]  ovf_cnt;

  assign in_accx  = in_frame[15:0];
  assign in_accy  = in_frame[31:16];
  assign in_accz  = in_frame[47:32];
  assign in_gyrox = in_frame[63:48];
  assign in_gyroy = in_frame[79:64];
  assign in_gyroz = in_frame[95:80];

  imu_sample_fifo #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_accx(in_accx), .in_accy(in_accy), .in_accz(in_accz),
    .in_gyrox(in_gyrox), .in_gyroy(in_gyroy), .in_gyroz(in_gyroz),
    .flush(flush), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .full(full),
    .empty(empty), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [95:0] exp_q[$];
  int          mon_widx = 0;
  bit          last_pop = 1'b0;
  bit          m_prev = 1'b0;
  int          ovf_exp = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [95:0] frm, input logic rdy,
                               input logic fl, input logic rs);
    in_valid  = iv;
    in_frame  = frm;
    out_ready = rdy;
    flush     = fl;
    reset     = rs;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [95:0] rand_frame();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: frames are admitted if there is room, counting the slot freed by a pop this edge.
  always @(posedge clk) begin
    int occ;
    bit cap;
    occ = exp_q.size() + (last_pop ? 1 : 0);
    cap = in_valid && !m_prev;
    if (reset) begin
      m_prev  = 1'b0;
      ovf_exp = 0;
    end else begin
      m_prev = in_valid;
      if (cap && !flush) begin
        if (occ < DEPTH || last_pop) exp_q.push_back(in_frame);
        else if (ovf_exp < 255) ovf_exp++;
      end
    end
  end

  // Monitor: compares the presented word and status, then consumes on handshake.
  always @(negedge clk) begin
    logic [95:0] hf;
    checkOutput("count", 32'(count), 32'(exp_q.size()));
    checkOutput("empty", 32'(empty), 32'(exp_q.size() == 0));
    checkOutput("full", 32'(full), 32'(exp_q.size() == DEPTH));
    checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(ovf_exp));
    if (exp_q.size() > 0) begin
      hf = exp_q[0];
      checkOutput("out_data", 32'(out_data), 32'(hf[mon_widx*16 +: 16]));
      checkOutput("out_idx", 32'(out_idx), 32'(mon_widx));
      checkOutput("out_last", 32'(out_last), 32'(mon_widx == 5));
    end else begin
      checkOutput("out_data_idle", 32'(out_data), 32'h0);
      checkOutput("out_idx_idle", 32'(out_idx), 32'h0);
    end
    last_pop = 1'b0;
    if (reset || flush) begin
      exp_q.delete();
      mon_widx = 0;
    end else if (exp_q.size() > 0 && out_ready) begin
      if (mon_widx == 5) begin
        void'(exp_q.pop_front());
        mon_widx = 0;
        last_pop = 1'b1;
      end else begin
        mon_widx++;
      end
    end
  end

  initial begin
    logic [95:0] f1;
    logic [95:0] fr;
    int          phase;
    f1 = {16'h0B0C, 16'h090A, 16'h0708, 16'h0506, 16'h0304, 16'h0102};
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick(3);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_empty", 32'(empty), 32'h1);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_ovf", 32'(ovf_cnt), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_out_last", 32'(out_last), 32'h0);

    // Single frame streamed with out_ready held high.
    applyStimulus(1'b1, f1, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("single_valid", 32'(out_valid), 32'h1);
    checkOutput("single_word0", 32'(out_data), 32'h0102);
    applyStimulus(1'b0, f1, 1'b1, 1'b0, 1'b0);
    tick(5);
    checkOutput("single_word5", 32'(out_data), 32'h0B0C);
    checkOutput("single_last", 32'(out_last), 32'h1);
    tick(1);
    checkOutput("single_empty", 32'(empty), 32'h1);

    // Backpressure holds the word; three ready toggles advance exactly two words.
    applyStimulus(1'b1, f1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, f1, 1'b0, 1'b0, 1'b0);
    tick(10);
    checkOutput("bp_hold_data", 32'(out_data), 32'h0102);
    checkOutput("bp_hold_idx", 32'(out_idx), 32'h0);
    out_ready = 1'b1; tick(1);
    out_ready = 1'b0; tick(1);
    out_ready = 1'b1; tick(1);
    out_ready = 1'b0;
    checkOutput("bp_adv_idx", 32'(out_idx), 32'h2);
    checkOutput("bp_adv_data", 32'(out_data), 32'h0506);
    flush = 1'b1; tick(1); flush = 1'b0;

    // Overflow: ten captures into eight slots.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0); tick(1);
      in_valid = 1'b0; tick(1);
    end
    checkOutput("ovf_count", 32'(count), 32'h8);
    checkOutput("ovf_full", 32'(full), 32'h1);
    checkOutput("ovf_cnt2", 32'(ovf_cnt), 32'h2);
    out_ready = 1'b1; tick(48);
    checkOutput("ovf_drained", 32'(empty), 32'h1);

    // Full FIFO with a cap coinciding with the head frame's last word.
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0); tick(1);
      in_valid = 1'b0; tick(1);
    end
    out_ready = 1'b1; tick(5);
    applyStimulus(1'b1, rand_frame(), 1'b1, 1'b0, 1'b0); tick(1);
    checkOutput("fullpop_count", 32'(count), 32'h8);
    checkOutput("fullpop_ovf", 32'(ovf_cnt), 32'h2);
    in_valid = 1'b0; tick(48);
    checkOutput("fullpop_drained", 32'(empty), 32'h1);

    // Level hold captures once; a one-cycle low re-arms.
    applyStimulus(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0); tick(50);
    checkOutput("hold_count1", 32'(count), 32'h1);
    in_valid = 1'b0; tick(1);
    applyStimulus(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0); tick(1);
    checkOutput("hold_count2", 32'(count), 32'h2);
    in_valid = 1'b0; tick(1);

    // Flush mid-frame, then a capture coinciding with flush.
    flush = 1'b1; tick(1); flush = 1'b0;
    applyStimulus(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0); tick(1);
    applyStimulus(1'b0, in_frame, 1'b1, 1'b0, 1'b0); tick(3);
    checkOutput("flush_mid_idx", 32'(out_idx), 32'h3);
    applyStimulus(1'b0, in_frame, 1'b0, 1'b1, 1'b0); tick(1);
    flush = 1'b0;
    checkOutput("flush_empty", 32'(empty), 32'h1);
    checkOutput("flush_idx", 32'(out_idx), 32'h0);
    checkOutput("flush_ovf_kept", 32'(ovf_cnt), 32'h2);
    applyStimulus(1'b1, rand_frame(), 1'b0, 1'b1, 1'b0); tick(1);
    applyStimulus(1'b0, in_frame, 1'b0, 1'b0, 1'b0); tick(1);
    checkOutput("flush_cap_count", 32'(count), 32'h0);
    checkOutput("flush_cap_ovf", 32'(ovf_cnt), 32'h2);

    // Overflow counter saturation.
    for (int k = 0; k < 265; k++) begin
      applyStimulus(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0); tick(1);
      in_valid = 1'b0; tick(1);
    end
    checkOutput("sat_ovf", 32'(ovf_cnt), 32'hFF);

    // Reset mid-frame clears the overflow counter too.
    out_ready = 1'b1; tick(3);
    applyStimulus(1'b0, in_frame, 1'b0, 1'b0, 1'b1); tick(1);
    reset = 1'b0;
    checkOutput("rstmid_ovf", 32'(ovf_cnt), 32'h0);
    checkOutput("rstmid_empty", 32'(empty), 32'h1);
    checkOutput("rstmid_idx", 32'(out_idx), 32'h0);

    // in_valid held high across reset release yields one capture.
    applyStimulus(1'b1, rand_frame(), 1'b0, 1'b0, 1'b1); tick(2);
    reset = 1'b0; tick(5);
    checkOutput("rstrel_count", 32'(count), 32'h1);
    in_valid = 1'b0; tick(1);

    // Randomised traffic with phases of light and heavy backpressure.
    phase = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) phase = $urandom_range(0, 3);
      if (!in_valid) fr = rand_frame();
      else fr = in_frame;
      applyStimulus($urandom_range(0, 2) == 0, fr,
                    $urandom_range(0, 3) < phase + 1,
                    $urandom_range(0, 199) == 0,
                    $urandom_range(0, 999) == 0);
      if (!in_valid) in_frame = rand_frame();
      tick(1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imu_sample_fifo.md
# imu_sample_fifo

Frame buffer directly downstream of the MPU-6050 I2C reader. It captures each completed 6-axis sample frame (accX/Y/Z, gyroX/Y/Z, 16 bits each) when the reader raises `valid`, and stores up to DEPTH frames. It replays them as a serial stream of 16-bit words with a valid/ready handshake, so a slower consumer (UART packer, filter) can drain samples without stalling the I2C sequencer.

## Interface
- DEPTH, 8, frame capacity; power of two, ≥2
- AW, 3, log2(DEPTH)
- clk  in  1  system clock (same as the I2C reader)
- reset  in  1  synchronous, active-high
- in_valid  in  1  reader `valid` level; a frame is captured on its 0→1 edge
- in_accx, in_accy, in_accz, in_gyrox, in_gyroy, in_gyroz  in  16 each  sample words, stable while in_valid high
- flush  in  1  synchronous clear of stored frames
- out_data  out  16  current word of the head frame
- out_idx  out  3  word index: 0 accX, 1 accY, 2 accZ, 3 gyroX, 4 gyroY, 5 gyroZ
- out_last  out  1  high when out_idx==5
- out_valid  out  1  head frame present
- out_ready  in  1  consumer accepts out_data this cycle
- count  out  AW+1  stored frames, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- ovf_cnt  out  8  frames dropped because full; saturates at 255

## Operation
- Storage: DEPTH×96-bit register array, write pointer wp, read pointer rp (AW bits, wrap modulo DEPTH), count register, word counter widx (0..5).
- Edge detect: in_prev <= in_valid; cap = in_valid & ~in_prev. in_prev resets to 0, so in_valid held high through reset release yields exactly one capture.
- Push: on cap, if (count<DEPTH) or a pop occurs in the same cycle: mem[wp] <= {gyroz,gyroy,gyrox,accz,accy,accx}, wp++. Otherwise the frame is dropped and ovf_cnt increments (saturating).
- Read side: out_valid = ~empty. out_data = 16-bit slice widx of mem[rp]. out_idx = widx. When out_valid & out_ready: if widx<5, widx++. If widx==5, pop: widx<=0, rp++.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Word handshake: out_data/out_idx hold stable while out_valid & ~out_ready. A frame is never partially dropped.
- flush: wp, rp, count, widx <= 0. ovf_cnt and in_prev are still updated normally. A cap in the flush cycle is discarded and not counted as overflow. Flush takes priority over push and pop.
- Reset: clears all state. out_valid=0, out_data=0 (mem not cleared; out_data is gated to 0 when empty), out_idx=0, out_last=0, count=0, empty=1, full=0, ovf_cnt=0.

## Timing
- Capture latency: cap in cycle N → count/out_valid updated at the edge ending N, so they are visible in cycle N+1, with out_idx=0 and out_data=accX.
- Drain: a frame needs 6 accepted cycles. With out_ready held high, a frame streams in 6 consecutive cycles. The next frame's accX follows in the next cycle with no bubble.
- Full with a simultaneous last-word pop and cap: the push is accepted, count stays DEPTH, ovf_cnt is unchanged.
- Empty with a simultaneous cap: out_valid rises the next cycle. There is no same-cycle bypass.
- Pointer wrap: wp/rp roll from DEPTH−1 to 0 with no gap. full/empty derive from count, not pointer compare.
- in_valid held high for many cycles captures one frame only. Re-arming requires in_valid low for ≥1 cycle.

## Test plan
- Single frame: after reset, pulse in_valid with accX=0x0102…gyroZ=0x0B0C and out_ready=1 → out_valid goes high the next cycle. Over six cycles out_data = 0x0102, 0x0304, …, 0x0B0C with out_idx 0..5, and out_last only on the sixth. Then empty=1.
- Backpressure: store one frame, out_ready=0 for 10 cycles → out_data stays 0x0102 with out_idx=0. Toggle out_ready 1,0,1 → exactly two words advance.
- Overflow: with out_ready=0, capture 10 frames at DEPTH=8 → count=8, full=1, ovf_cnt=2. Draining all returns frames 1..8 in order; 9 and 10 are absent.
- Full plus simultaneous pop and cap: fill to 8 and align a cap with the sixth word of the head frame → count stays 8, ovf_cnt unchanged, and the new frame appears last.
- Level hold and edge re-arm: hold in_valid=1 for 50 cycles → count=1. Drop it for 1 cycle and raise it again → count=2.
- Flush and reset mid-frame: stop after 3 words accepted, then assert flush → empty=1 and out_idx=0 while ovf_cnt is retained. Repeat the test with reset instead → ovf_cnt=0.
